instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the single-cycle MIPS core (top).

---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, loadable word-addressed imem, valid/ready output to the core.
// Latency: first instruction 1 cycle after rst release; 2 cycles after a redirect cycle.
// Backpressure: instr_valid && !out_ready holds every output and the PC bit-stable until accepted.
module instr_fetch_unit #(
   parameter int          IMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fault
);

   // Word index width into imem; byte span used for range checks so that the
   // low address bits take part in the compare without changing its result.
   localparam int          IDX_W      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_FAULT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0] r_imem [IMEM_DEPTH];
   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic [31:0] r_instr_pc;
   logic [31:0] r_pc_plus4;
   logic        r_instr_valid;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   state_t           w_state_nxt;
   logic             w_pc_aligned;
   logic             w_pc_in_range;
   logic             w_pc_legal;
   logic [IDX_W-1:0] w_pc_idx;
   logic [31:0]      w_pc_inc;
   logic             w_out_free;
   logic             w_advance;
   logic             w_fetch;
   logic             w_trap;
   logic             w_load_hit;
   logic [IDX_W-1:0] w_load_idx;
   logic [31:0]      w_pc_nxt;
   logic             w_instr_valid_nxt;

   // A PC is fetchable only if word aligned and inside imem.
   assign w_pc_aligned  = (r_pc[1:0] == 2'b00);
   assign w_pc_in_range = (r_pc < IMEM_BYTES);
   assign w_pc_legal    = w_pc_aligned && w_pc_in_range;
   assign w_pc_idx      = r_pc[IDX_W+1:2];
   assign w_pc_inc      = r_pc + 32'd4;

   // The output slot can take a new word when empty or being accepted now.
   // Redirect wins over both advance and stall.
   assign w_out_free = !r_instr_valid || out_ready;
   assign w_advance  = (r_state == S_FETCH) && !redirect_valid && w_out_free;
   assign w_fetch    = w_advance && w_pc_legal;
   assign w_trap     = w_advance && !w_pc_legal;

   // Loads beyond imem are dropped rather than aliased onto low words.
   assign w_load_hit = load_en && (load_addr < IMEM_BYTES);
   assign w_load_idx = load_addr[IDX_W+1:2];

   // Next-state logic: redirect always returns to FETCH, an illegal fetch parks in FAULT.
   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = S_FETCH;
      end else if (w_trap) begin
         w_state_nxt = S_FAULT;
      end
   end

   // Next PC and valid flag; everything not named here holds its value.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_instr_valid_nxt = r_instr_valid;
      if (redirect_valid) begin
         // In-flight word is dropped; the redirect target is fetched next cycle.
         w_pc_nxt          = redirect_pc;
         w_instr_valid_nxt = 1'b0;
      end else if (w_fetch) begin
         w_pc_nxt          = w_pc_inc;
         w_instr_valid_nxt = 1'b1;
      end else if (w_trap) begin
         // PC stays on the offending address so it is visible for debug.
         w_instr_valid_nxt = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC and valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_instr_valid <= 1'b0;
      end else begin
         r_pc          <= w_pc_nxt;
         r_instr_valid <= w_instr_valid_nxt;
      end
   end

   // Output payload captured only on a legal fetch, so stalls keep it bit-stable.
   // The imem read sees the pre-edge contents, so a same-cycle load returns old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_instruction <= 32'h0;
         r_instr_pc    <= 32'h0;
         r_pc_plus4    <= 32'h0;
      end else if (w_fetch) begin
         r_instruction <= r_imem[w_pc_idx];
         r_instr_pc    <= r_pc;
         r_pc_plus4    <= w_pc_inc;
      end
   end

   // Instruction memory write port; contents survive reset, but reset blocks writes.
   always_ff @(posedge clk) begin
      if (!rst && w_load_hit) begin
         r_imem[w_load_idx] <= load_data;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign instruction = r_instruction;
   assign instr_pc    = r_instr_pc;
   assign pc_plus4    = r_pc_plus4;
   assign instr_valid = r_instr_valid;
   assign fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized
// redirect/backpressure run checked against a stream-level reference model.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference contents of imem as the bench believes them to be.
   logic [31:0] mem_m [64];
   logic [31:0] prog [9];

   instr_fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_ready      (out_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .pc_plus4       (pc_plus4),
      .instr_valid    (instr_valid),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit legal_pc(input logic [31:0] p);
      return (p % 4 == 0) && (p / 4 < 64);
   endfunction

   task automatic do_load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
      if (a / 4 < 64) mem_m[a / 4] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_en = 1'b1; load_addr = 32'h0; load_data = 32'hBAD0BAD0;
      redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
      tick(); tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== 98'h0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b f=%b pc=%h ins=%h p4=%h, want all zero",
                  instr_valid, fault, instr_pc, instruction, pc_plus4);
      end
      load_en = 1'b0;
   endtask

   task automatic test_load_stream();
      // Load with the pipeline held idle by a redirect, then restart from reset.
      rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
      for (int i = 0; i < 9; i++) do_load(32'(i * 4), prog[i]);
      rst = 1'b1; redirect_valid = 1'b0;
      tick();
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         logic [31:0] ep;
         ep = 32'(i * 4);
         tick();
         n_checks++;
         if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, ep, prog[i], ep + 32'd4}) begin
            n_fail++;
            $display("FAIL stream[%0d]: got v=%b f=%b pc=%h ins=%h p4=%h, want pc=%h ins=%h",
                     i, instr_valid, fault, instr_pc, instruction, pc_plus4, ep, prog[i]);
         end
      end
   endtask

   task automatic test_stall();
      rst = 1'b1; tick();
      rst = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, 32'h8, 32'h210B000A, 32'hC}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b pc=%h ins=%h p4=%h, want pc=00000008 ins=210b000a",
                     k, instr_valid, instr_pc, instruction, pc_plus4);
         end
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, 32'hC, 32'h210C0014, 32'h10}) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b pc=%h ins=%h, want pc=0000000c ins=210c0014",
                  instr_valid, instr_pc, instruction);
      end
   endtask

   task automatic test_redirect();
      redirect_valid = 1'b1; redirect_pc = 32'h14;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if ({instr_valid, fault} !== 2'b00) begin
         n_fail++;
         $display("FAIL redirect_bubble: got v=%b f=%b, want v=0 f=0", instr_valid, fault);
      end
      tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, 32'h14, 32'h01494820, 32'h18}) begin
         n_fail++;
         $display("FAIL redirect_target: got v=%b pc=%h ins=%h p4=%h, want pc=00000014 ins=01494820",
                  instr_valid, instr_pc, instruction, pc_plus4);
      end
   endtask

   task automatic test_fault();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if ({instr_valid, fault} !== 2'b01) begin
         n_fail++;
         $display("FAIL fault_misaligned: got v=%b f=%b, want v=0 f=1", instr_valid, fault);
      end
      tick(); tick();
      n_checks++;
      if ({instr_valid, fault} !== 2'b01) begin
         n_fail++;
         $display("FAIL fault_held: got v=%b f=%b, want v=0 f=1", instr_valid, fault);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0;
      n_checks++;
      if ({instr_valid, fault} !== 2'b00) begin
         n_fail++;
         $display("FAIL fault_clear: got v=%b f=%b, want v=0 f=0", instr_valid, fault);
      end
      tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction} !== {2'b10, 32'h0, 32'h2109000A}) begin
         n_fail++;
         $display("FAIL fault_recover: got v=%b pc=%h ins=%h, want pc=00000000 ins=2109000a",
                  instr_valid, instr_pc, instruction);
      end
   endtask

   task automatic test_load_collision();
      logic [31:0] nd;
      nd = $urandom;
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick();
      // This cycle fetches word 8 while also overwriting it.
      redirect_valid = 1'b0;
      load_en = 1'b1; load_addr = 32'h23; load_data = nd;
      tick();
      load_en = 1'b0;
      n_checks++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h20, mem_m[8]}) begin
         n_fail++;
         $display("FAIL collision_old: got v=%b pc=%h ins=%h, want pc=00000020 ins=%h",
                  instr_valid, instr_pc, instruction, mem_m[8]);
      end
      mem_m[8] = nd;
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h20, nd}) begin
         n_fail++;
         $display("FAIL collision_new: got v=%b pc=%h ins=%h, want pc=00000020 ins=%h",
                  instr_valid, instr_pc, instruction, nd);
      end
   endtask

   task automatic test_full_run();
      redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b1;
      for (int i = 9; i < 64; i++) do_load(32'(i * 4), $urandom);
      // Out-of-range loads must not alias onto low words.
      do_load(32'h100, 32'hDEADBEEF);
      do_load(32'h400, 32'hFEEDFACE);
      do_load(32'hFFFFFFFC, 32'hCAFEF00D);
      redirect_valid = 1'b0;
      for (int i = 0; i < 64; i++) begin
         logic [31:0] ep;
         ep = 32'(i * 4);
         tick();
         n_checks++;
         if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, ep, mem_m[i], ep + 32'd4}) begin
            n_fail++;
            $display("FAIL full_run[%0d]: got v=%b f=%b pc=%h ins=%h p4=%h, want pc=%h ins=%h",
                     i, instr_valid, fault, instr_pc, instruction, pc_plus4, ep, mem_m[i]);
         end
      end
      tick();
      n_checks++;
      if ({instr_valid, fault} !== 2'b01) begin
         n_fail++;
         $display("FAIL end_of_imem: got v=%b f=%b, want v=0 f=1", instr_valid, fault);
      end
   endtask

   task automatic test_reset_midstream();
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      out_ready = 1'b0;
      tick();
      n_checks++;
      if ({instr_valid, instr_pc, instruction} !== {1'b1, 32'h14, mem_m[5]}) begin
         n_fail++;
         $display("FAIL pre_reset_hold: got v=%b pc=%h ins=%h, want pc=00000014 ins=%h",
                  instr_valid, instr_pc, instruction, mem_m[5]);
      end
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      load_en = 1'b1; load_addr = 32'h0; load_data = ~mem_m[0];
      tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== 98'h0) begin
         n_fail++;
         $display("FAIL midstream_reset: got v=%b f=%b pc=%h ins=%h p4=%h, want all zero",
                  instr_valid, fault, instr_pc, instruction, pc_plus4);
      end
      rst = 1'b0; redirect_valid = 1'b0; load_en = 1'b0; out_ready = 1'b1;
      tick();
      n_checks++;
      if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !== {2'b10, 32'h0, mem_m[0], 32'h4}) begin
         n_fail++;
         $display("FAIL post_reset_first: got v=%b pc=%h ins=%h, want pc=00000000 ins=%h",
                  instr_valid, instr_pc, instruction, mem_m[0]);
      end
   endtask

   // Random redirects and backpressure; the model tracks only the address of the
   // word that should be presented next and the memory image.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] rpc;
      logic        v_before;
      logic        rdy;
      logic        rdv;
      int          r;
      exp_pc = 32'h0;
      for (int c = 0; c < 800; c++) begin
         v_before = instr_valid;
         r   = int'($urandom_range(0, 99));
         rdv = (c == 0) || (r < 6) || (fault && r < 30);
         r   = int'($urandom_range(0, 9));
         if (r < 8)       rpc = 32'($urandom_range(0, 63)) << 2;
         else if (r == 8) rpc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
         else             rpc = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
         rdy = ($urandom_range(0, 3) != 0);
         out_ready = rdy; redirect_valid = rdv; redirect_pc = rpc;
         tick();
         if (rdv) begin
            exp_pc = rpc;
            n_checks++;
            if ({instr_valid, fault} !== 2'b00) begin
               n_fail++;
               $display("FAIL rnd_redirect[%0d]: got v=%b f=%b, want v=0 f=0", c, instr_valid, fault);
            end
         end else begin
            if (v_before && rdy) exp_pc = exp_pc + 32'd4;
            n_checks++;
            if (legal_pc(exp_pc)) begin
               if ({instr_valid, fault, instr_pc, instruction, pc_plus4} !==
                   {2'b10, exp_pc, mem_m[exp_pc / 4], exp_pc + 32'd4}) begin
                  n_fail++;
                  $display("FAIL rnd_word[%0d]: got v=%b f=%b pc=%h ins=%h p4=%h, want pc=%h ins=%h",
                           c, instr_valid, fault, instr_pc, instruction, pc_plus4, exp_pc, mem_m[exp_pc / 4]);
               end
            end else if ({instr_valid, fault} !== 2'b01) begin
               n_fail++;
               $display("FAIL rnd_fault[%0d]: got v=%b f=%b at pc %h, want v=0 f=1", c, instr_valid, fault, exp_pc);
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      prog[0] = 32'h2109000A; prog[1] = 32'h210A0012; prog[2] = 32'h210B000A;
      prog[3] = 32'h210C0014; prog[4] = 32'h210D001E; prog[5] = 32'h01494820;
      prog[6] = 32'h8D4C0008; prog[7] = 32'hAD4B000A; prog[8] = 32'h8D4D000A;
      for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
      test_reset();
      test_load_stream();
      test_stall();
      test_redirect();
      test_fault();
      test_load_collision();
      test_full_run();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
